// File: rtl/raw_stream_tx.sv
// rtl/raw_stream_tx.sv - raw Bayer pixel stream transmitter feeding the ISP filter chain
//
// Purpose:
//   Drains an upstream non-show-ahead pixel FIFO and emits frames of HEIGHT
//   lines. Each line is WIDTH back-to-back pixels on per_raw_data/per_raw_clken,
//   followed by HBLANK idle cycles. VBLANK idle cycles follow the last line of a
//   frame. A line is only started once the FIFO holds the whole line, so a line
//   can never stall half way: downstream line buffers and Bayer phase counters
//   advance on every clken.
//
// Ports:
//   pclk           pixel clock, the only clock
//   rst            synchronous active-high reset
//   enable         start/continue frames; looked at in IDLE and at the end of VBLANK
//   fifo_rdata     FIFO read data, valid the cycle after fifo_rdreq
//   fifo_rdusedw   FIFO fill level in words
//   fifo_empty     FIFO empty flag
//   fifo_rdreq     FIFO read strobe (registered)
//   per_raw_data   pixel to the ISP, holds its last value while clken is low
//   per_raw_clken  pixel valid, exactly WIDTH consecutive cycles per line
//   frame_start    pulse with the clken of pixel 0 of line 0
//   line_end       pulse with the clken of pixel WIDTH-1 of every line
//   busy           low only while the FSM is in IDLE
//   underflow_err  sticky, set when a read is issued against an empty FIFO
//
// Build option:
//   RAW_TX_FLUSH_EN  when defined, two lines of WIDTH zero pixels (no FIFO reads,
//                    no level wait) follow the last active line of every frame so
//                    that 5x5 line-buffer filters downstream flush their last rows.

module raw_stream_tx #(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1936,
    parameter int HEIGHT = 1096,
    parameter int HBLANK = 64,
    parameter int VBLANK = 1024,
    parameter int LVLW   = 13
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            enable,
    input  logic [BITS-1:0] fifo_rdata,
    input  logic [LVLW-1:0] fifo_rdusedw,
    input  logic            fifo_empty,
    output logic            fifo_rdreq,
    output logic [BITS-1:0] per_raw_data,
    output logic            per_raw_clken,
    output logic            frame_start,
    output logic            line_end,
    output logic            busy,
    output logic            underflow_err
);

`ifdef RAW_TX_FLUSH_EN
    localparam int FLUSH_LINES = 2;
`else
    localparam int FLUSH_LINES = 0;
`endif

    localparam int TOTAL_LINES = HEIGHT + FLUSH_LINES;

    localparam int PIX_W  = (WIDTH > 1)       ? $clog2(WIDTH)       : 1;
    localparam int HB_W   = (HBLANK > 1)      ? $clog2(HBLANK)      : 1;
    localparam int VB_W   = (VBLANK > 1)      ? $clog2(VBLANK)      : 1;
    localparam int LINE_W = (TOTAL_LINES > 1) ? $clog2(TOTAL_LINES) : 1;

    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(WIDTH - 1);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HBLANK - 1);
    localparam logic [VB_W-1:0]   VB_LAST   = VB_W'(VBLANK - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(TOTAL_LINES - 1);
    localparam logic [LVLW-1:0]   LVL_NEED  = LVLW'(WIDTH);

`ifdef RAW_TX_FLUSH_EN
    // Last line that reads the FIFO; every later line of the frame is a flush line.
    localparam logic [LINE_W-1:0] LINE_ACT_LAST = LINE_W'(HEIGHT - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACTIVE,
        S_HBLANK,
        S_VBLANK
    } state_t;

    state_t              state_q;
    logic [PIX_W-1:0]    pix_cnt_q;
    logic [LINE_W-1:0]   line_cnt_q;
    logic [HB_W-1:0]     hb_cnt_q;
    logic [VB_W-1:0]     vb_cnt_q;
    logic                rdreq_q;
    logic                flush_q;
    logic                busy_q;

    // Output stage, one cycle behind the ACTIVE (issue) cycles.
    logic                clken_q;
    logic                zero_q;
    logic                frame_start_q;
    logic                line_end_q;
    logic [BITS-1:0]     hold_q;
    logic                underflow_q;

    logic                level_ok;
    logic                issue;

    // A line may start only when every one of its pixels is already buffered.
    assign level_ok = (fifo_rdusedw >= LVL_NEED);

    // Every ACTIVE cycle produces one pixel on the next cycle.
    assign issue = (state_q == S_ACTIVE);

    // The FIFO's own output register is the pixel register stage: the word read
    // with rdreq appears on fifo_rdata in the same cycle clken rises. Between
    // lines the last emitted pixel is held rather than zeroed.
    assign per_raw_data  = !clken_q ? hold_q : (zero_q ? '0 : fifo_rdata);
    assign per_raw_clken = clken_q;
    assign frame_start   = frame_start_q;
    assign line_end      = line_end_q;
    assign fifo_rdreq    = rdreq_q;
    assign busy          = busy_q;
    assign underflow_err = underflow_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            hb_cnt_q      <= '0;
            vb_cnt_q      <= '0;
            rdreq_q       <= 1'b0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            clken_q       <= 1'b0;
            zero_q        <= 1'b0;
            frame_start_q <= 1'b0;
            line_end_q    <= 1'b0;
            hold_q        <= '0;
            underflow_q   <= 1'b0;
        end else begin
            clken_q       <= issue;
            zero_q        <= issue & flush_q;
            frame_start_q <= issue && (pix_cnt_q == '0) && (line_cnt_q == '0) && !flush_q;
            line_end_q    <= issue && (pix_cnt_q == PIX_LAST);
            hold_q        <= per_raw_data;
            underflow_q   <= underflow_q | (rdreq_q & fifo_empty);

            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q    <= S_WAIT;
                        line_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (level_ok) begin
                        state_q   <= S_ACTIVE;
                        pix_cnt_q <= '0;
                        rdreq_q   <= 1'b1;
                        flush_q   <= 1'b0;
                    end
                end

                S_ACTIVE: begin
                    if (pix_cnt_q == PIX_LAST) begin
                        state_q  <= S_HBLANK;
                        rdreq_q  <= 1'b0;
                        hb_cnt_q <= '0;
                    end else begin
                        pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                    end
                end

                // The first HBLANK cycle is the first cycle with rdreq low. On the
                // last blank cycle the level check of WAIT is folded in, so a line
                // whose data is already buffered follows after exactly HBLANK idle
                // cycles; WAIT is only entered when the FIFO is short.
                S_HBLANK: begin
                    if (hb_cnt_q == HB_LAST) begin
                        if (line_cnt_q == LINE_LAST) begin
                            state_q  <= S_VBLANK;
                            vb_cnt_q <= '0;
                            flush_q  <= 1'b0;
                        end else begin
                            line_cnt_q <= line_cnt_q + LINE_W'(1);
                            pix_cnt_q  <= '0;
`ifdef RAW_TX_FLUSH_EN
                            if (line_cnt_q >= LINE_ACT_LAST) begin
                                state_q <= S_ACTIVE;
                                flush_q <= 1'b1;
                            end else
`endif
                            if (level_ok) begin
                                state_q <= S_ACTIVE;
                                rdreq_q <= 1'b1;
                                flush_q <= 1'b0;
                            end else begin
                                state_q <= S_WAIT;
                            end
                        end
                    end else begin
                        hb_cnt_q <= hb_cnt_q + HB_W'(1);
                    end
                end

                S_VBLANK: begin
                    if (vb_cnt_q == VB_LAST) begin
                        if (enable) begin
                            state_q    <= S_WAIT;
                            line_cnt_q <= '0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        vb_cnt_q <= vb_cnt_q + VB_W'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    rdreq_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
